// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - SPI slave serial front end between the SPI pins and the RX/TX FIFOs
module spi_slave_shifter #(
    parameter int               WIDTH       = 8,
    parameter int               CPOL        = 0,
    parameter int               CPHA        = 0,
    parameter int               LSB_FIRST   = 0,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] FILL_WORD   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_wr_en,
    input  logic             rx_full,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_rd_en,
    input  logic             tx_empty,
    output logic             rx_overrun,
    output logic             tx_underrun,
    output logic             frame_error,
    output logic             busy
);
    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic             IDLE_LVL = (CPOL != 0);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, XFER} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WIDTH-1:0]       rx_sr, tx_sr, rx_word, load_word;
    logic                   use_fill, rx_done;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic                   cs_fall, do_sample, do_shift, word_done;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign lead_edge   = (sclk_d == IDLE_LVL) && (sclk_s != IDLE_LVL);
    assign trail_edge  = (sclk_d != IDLE_LVL) && (sclk_s == IDLE_LVL);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    assign cs_fall     = cs_d && !cs_s;

    // A shift edge seen while the bit counter is zero belongs to the first bit
    // of a word, which LOAD has already placed on miso.
    assign do_sample = (state == XFER) && !cs_s && sample_edge;
    assign do_shift  = (state == XFER) && !cs_s && shift_edge && (bit_cnt != '0);
    assign word_done = do_sample && (bit_cnt == LAST_BIT);

    assign rx_word   = (LSB_FIRST != 0) ? {mosi_s, rx_sr[WIDTH-1:1]} : {rx_sr[WIDTH-2:0], mosi_s};
    assign load_word = use_fill ? FILL_WORD : tx_data;

    assign busy       = !cs_s;
    assign miso_oe    = !cs_s;
    assign rx_wr_en   = rx_done && !rx_full && !rst;
    assign rx_overrun = rx_done && rx_full && !rst;

    always_comb begin
        state_nxt   = state;
        tx_rd_en    = 1'b0;
        tx_underrun = 1'b0;
        frame_error = 1'b0;
        if (cs_s) begin
            state_nxt   = IDLE;
            frame_error = (state != IDLE) && (bit_cnt != '0);
        end else begin
            case (state)
                IDLE:    if (cs_fall) state_nxt = FETCH;
                FETCH: begin
                    state_nxt   = LOAD;
                    tx_rd_en    = !tx_empty;
                    tx_underrun = tx_empty;
                end
                LOAD:    state_nxt = XFER;
                XFER:    if (word_done) state_nxt = FETCH;
                default: state_nxt = IDLE;
            endcase
        end
        if (rst) begin
            tx_rd_en    = 1'b0;
            tx_underrun = 1'b0;
            frame_error = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
            cs_sync   <= {SYNC_STAGES{1'b1}};
            mosi_sync <= '0;
            sclk_d    <= IDLE_LVL;
            cs_d      <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            use_fill  <= 1'b0;
            miso      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            state     <= state_nxt;
            rx_done   <= word_done;

            if (cs_s) begin
                bit_cnt <= '0;
            end else if (do_sample) begin
                rx_sr   <= rx_word;
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
                if (word_done) rx_data <= rx_word;
            end

            if (state == FETCH) use_fill <= tx_empty;

            if (state == LOAD && !cs_s) begin
                miso  <= (LSB_FIRST != 0) ? load_word[0] : load_word[WIDTH-1];
                tx_sr <= (LSB_FIRST != 0) ? (load_word >> 1) : (load_word << 1);
            end else if (do_shift) begin
                miso  <= (LSB_FIRST != 0) ? tx_sr[0] : tx_sr[WIDTH-1];
                tx_sr <= (LSB_FIRST != 0) ? (tx_sr >> 1) : (tx_sr << 1);
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_shifter.sv
// tb/tb_spi_slave_shifter.sv - scoreboard bench: mode 0 and mode 3 slaves driven by a behavioural SPI master
`timescale 1ns/1ps
module tb_spi_slave_shifter;
    localparam int         H     = 5;
    localparam logic [7:0] FILL0 = 8'h00;
    localparam logic [7:0] FILL1 = 8'hE7;

    logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b0, rx_full = 1'b0;
    logic [1:0] cs_n = 2'b11;
    logic [7:0] tx_data = 8'h00;
    logic       tx_empty = 1'b1;
    logic [1:0] miso_v, miso_oe_v, rx_wr_en_v, tx_rd_en_v, rx_ovr_v, tx_und_v, ferr_v, busy_v;
    logic [7:0] rx_data_v [2];

    always #5 clk = ~clk;

    spi_slave_shifter #(.WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .SYNC_STAGES(2), .FILL_WORD(FILL0)) u_mode0 (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n[0]), .mosi(mosi),
        .miso(miso_v[0]), .miso_oe(miso_oe_v[0]), .rx_data(rx_data_v[0]), .rx_wr_en(rx_wr_en_v[0]),
        .rx_full(rx_full), .tx_data(tx_data), .tx_rd_en(tx_rd_en_v[0]), .tx_empty(tx_empty),
        .rx_overrun(rx_ovr_v[0]), .tx_underrun(tx_und_v[0]), .frame_error(ferr_v[0]), .busy(busy_v[0]));

    spi_slave_shifter #(.WIDTH(8), .CPOL(1), .CPHA(1), .LSB_FIRST(0), .SYNC_STAGES(3), .FILL_WORD(FILL1)) u_mode3 (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n[1]), .mosi(mosi),
        .miso(miso_v[1]), .miso_oe(miso_oe_v[1]), .rx_data(rx_data_v[1]), .rx_wr_en(rx_wr_en_v[1]),
        .rx_full(rx_full), .tx_data(tx_data), .tx_rd_en(tx_rd_en_v[1]), .tx_empty(tx_empty),
        .rx_overrun(rx_ovr_v[1]), .tx_underrun(tx_und_v[1]), .frame_error(ferr_v[1]), .busy(busy_v[1]));

    typedef struct packed { logic inst; logic ovr; logic [7:0] data; } rx_ev_t;
    typedef struct packed { logic inst; logic und; } tx_ev_t;

    rx_ev_t     rx_exp[$];
    tx_ev_t     tx_exp[$];
    logic [7:0] tx_fifo[$];
    logic [7:0] tx_model[$];
    logic [7:0] frame_mosi[$];
    logic [7:0] last_rx [2] = '{8'h00, 8'h00};
    int         ferr_cnt [2] = '{0, 0};
    int         ferr_exp [2] = '{0, 0};
    int         vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // TX FIFO stand-in: readData is valid the cycle after the read strobe
    always @(posedge clk) begin
        if ((|tx_rd_en_v) && tx_fifo.size() > 0) tx_data <= tx_fifo.pop_front();
        tx_empty <= (tx_fifo.size() == 0);
    end

    always @(negedge clk) begin : monitor
        rx_ev_t rev;
        tx_ev_t tev;
        for (int m = 0; m < 2; m++) begin
            if (rx_wr_en_v[m] || rx_ovr_v[m]) begin
                if (rx_exp.size() == 0) begin
                    check("rx_unexpected", {rx_wr_en_v[m], rx_ovr_v[m]}, 32'd0);
                end else begin
                    rev = rx_exp.pop_front();
                    check("rx_inst", m, rev.inst);
                    check("rx_overrun", rx_ovr_v[m], rev.ovr);
                    check("rx_wr_en", rx_wr_en_v[m], !rev.ovr);
                    check("rx_data", rx_data_v[m], rev.data);
                end
            end
            if (tx_rd_en_v[m] || tx_und_v[m]) begin
                if (tx_exp.size() == 0) begin
                    check("fetch_unexpected", {tx_rd_en_v[m], tx_und_v[m]}, 32'd0);
                end else begin
                    tev = tx_exp.pop_front();
                    check("fetch_inst", m, tev.inst);
                    check("tx_underrun", tx_und_v[m], tev.und);
                    check("tx_rd_en", tx_rd_en_v[m], !tev.und);
                end
            end
            if (ferr_v[m]) ferr_cnt[m]++;
        end
    end

    task automatic push_tx(input logic [7:0] w);
        tx_fifo.push_back(w);
        tx_model.push_back(w);
    endtask

    // Every fetch takes the oldest TX word, or the fill word when nothing is queued.
    task automatic model_fetch(input int m, output logic [7:0] word);
        tx_ev_t ev;
        ev.inst = m[0];
        ev.und  = (tx_model.size() == 0);
        if (ev.und) word = (m == 1) ? FILL1 : FILL0;
        else        word = tx_model.pop_front();
        tx_exp.push_back(ev);
    endtask

    task automatic cs_low(input int m);
        sclk = (m == 1);
        repeat (4) @(negedge clk);
        cs_n[m] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic cs_high(input int m);
        repeat (H) @(negedge clk);
        cs_n[m] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Master side, MSB first; miso is captured at the master's sampling edge.
    task automatic shift_bits(input int m, input int n, input logic [7:0] w, output logic [7:0] cap);
        cap = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (m == 0) begin
                mosi = w[7-i];
                repeat (H) @(negedge clk);
                cap  = {cap[6:0], miso_v[0]};
                sclk = 1'b1;
                repeat (H) @(negedge clk);
                sclk = 1'b0;
            end else begin
                sclk = 1'b0;
                mosi = w[7-i];
                repeat (H) @(negedge clk);
                cap  = {cap[6:0], miso_v[1]};
                sclk = 1'b1;
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic check_reset(input int m);
        check("rst_miso", miso_v[m], 0);
        check("rst_miso_oe", miso_oe_v[m], 0);
        check("rst_busy", busy_v[m], 0);
        check("rst_rx_data", rx_data_v[m], 0);
        check("rst_strobes", {rx_wr_en_v[m], tx_rd_en_v[m], rx_ovr_v[m], tx_und_v[m], ferr_v[m]}, 0);
    endtask

    task automatic run_frame(input int m, input int tail_bits);
        logic [7:0] cur, nxt, cap;
        rx_ev_t     rev;
        model_fetch(m, cur);
        cs_low(m);
        check("busy", busy_v[m], 1);
        check("miso_oe", miso_oe_v[m], 1);
        foreach (frame_mosi[k]) begin
            rev.inst = m[0];
            rev.ovr  = rx_full;
            rev.data = frame_mosi[k];
            rx_exp.push_back(rev);
            model_fetch(m, nxt);
            shift_bits(m, 8, frame_mosi[k], cap);
            check("miso_word", cap, cur);
            cur       = nxt;
            last_rx[m] = frame_mosi[k];
        end
        if (tail_bits > 0) begin
            shift_bits(m, tail_bits, 8'($urandom), cap);
            ferr_exp[m]++;
        end
        cs_high(m);
        for (int i = 0; i < 50 && (rx_exp.size() != 0 || tx_exp.size() != 0); i++) @(negedge clk);
        check("rx_pending", rx_exp.size(), 0);
        check("fetch_pending", tx_exp.size(), 0);
        check("frame_error_count", ferr_cnt[m], ferr_exp[m]);
        check("rx_data_hold", rx_data_v[m], last_rx[m]);
        check("busy_idle", busy_v[m], 0);
    endtask

    task automatic reset_mid(input int m);
        logic [7:0] cur, cap;
        model_fetch(m, cur);
        cs_low(m);
        shift_bits(m, 3, 8'($urandom), cap);
        rst = 1'b1;
        @(negedge clk);
        check_reset(m);
        cs_n[m] = 1'b1;
        sclk    = (m == 1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        last_rx[m] = 8'h00;
        check("fetch_pending_rst", tx_exp.size(), 0);
        check("frame_error_rst", ferr_cnt[m], ferr_exp[m]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (5) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        push_tx(8'hA5);
        frame_mosi = '{8'h3C};
        run_frame(0, 0);

        push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
        frame_mosi = '{8'h01, 8'h80, 8'hFF};
        run_frame(1, 0);

        frame_mosi = '{8'hC3};
        run_frame(0, 0);

        rx_full = 1'b1;
        push_tx(8'h5E);
        frame_mosi = '{8'h55};
        run_frame(0, 0);
        rx_full = 1'b0;

        push_tx(8'h77);
        frame_mosi.delete();
        run_frame(0, 5);
        push_tx(8'h3D);
        frame_mosi = '{8'h9A};
        run_frame(0, 0);

        reset_mid(0);
        push_tx(8'h24);
        frame_mosi = '{8'h42};
        run_frame(0, 0);

        for (int r = 0; r < 12; r++) begin
            int m, nt, nw, tail;
            m    = r % 2;
            nt   = $urandom_range(0, 3);
            nw   = $urandom_range(1, 3);
            tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            rx_full = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < nt; k++) push_tx(8'($urandom));
            frame_mosi.delete();
            for (int k = 0; k < nw; k++) frame_mosi.push_back(8'($urandom));
            run_frame(m, tail);
        end
        rx_full = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_slave_shifter.md
Name: spi_slave_shifter

Overview:
- Serial front end of the SPI slave, between the SPI pins and the slave's two FIFO instances. One FIFO is RX, the other is TX.
- Samples SCLK, CS_N and MOSI in the system clock domain and deserialises MOSI into WIDTH-bit words. Each completed word is pushed into the RX FIFO.
- Pops words from the TX FIFO and serialises them onto MISO.
- Flags overrun, underrun and aborted frames.

Parameters:
- WIDTH, 8: word size in bits; must match both FIFOs.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- LSB_FIRST, 0: 0 = MSB first on both MOSI and MISO.
- SYNC_STAGES, 2: flop stages on sclk, cs_n and mosi; minimum 2.
- FILL_WORD, 0: word shifted out when the TX FIFO is empty at fetch.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- sclk  in  1  SPI clock, asynchronous to clk.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data in, asynchronous.
- miso  out  1  SPI data out.
- miso_oe  out  1  MISO output enable; high while the synchronised cs_n is low.
- rx_data  out  WIDTH  word to the RX FIFO writeData.
- rx_wr_en  out  1  one-cycle write strobe to the RX FIFO.
- rx_full  in  1  RX FIFO full.
- tx_data  in  WIDTH  TX FIFO readData; valid the cycle after tx_rd_en.
- tx_rd_en  out  1  one-cycle read strobe to the TX FIFO.
- tx_empty  in  1  TX FIFO empty.
- rx_overrun  out  1  one-cycle pulse: completed word dropped because rx_full.
- tx_underrun  out  1  one-cycle pulse: FILL_WORD substituted because tx_empty.
- frame_error  out  1  one-cycle pulse: cs_n deasserted with a partial word.
- busy  out  1  high while the synchronised cs_n is low.

Behaviour:
- Clock and reset: clk rising edge, single domain. Reset is synchronous and active-high.
- Reset values:
  - miso=0, miso_oe=0, rx_data=0.
  - rx_wr_en, tx_rd_en, rx_overrun, tx_underrun, frame_error all 0; busy=0.
  - Bit counter 0; state IDLE.
  - Synchroniser flops: sclk to CPOL, cs_n to 1, mosi to 0.
- Synchronisers and edge detection:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchroniser stage with one further flop.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
- Clock ratio: clk must be at least 8x sclk. Edges closer together than 4 clk cycles are not required to be handled.
- States:
  - IDLE: cs_n sync high.
  - FETCH: one cycle. Assert tx_rd_en if !tx_empty; otherwise pulse tx_underrun and select FILL_WORD.
  - LOAD: one cycle. Load tx_data, or FILL_WORD, into the TX shift register. Drive the first bit on miso.
  - XFER: shifting.
- Transitions:
  - IDLE -> FETCH on cs_n falling edge (sync).
  - FETCH -> LOAD always.
  - LOAD -> XFER always.
  - XFER -> FETCH on the sample edge that completes bit WIDTH-1, so the next word is ready before its first shift edge.
  - Any state -> IDLE on cs_n sync high.
- MISO driving:
  - CPHA=0: bit 0 of each word is driven in LOAD; later bits change on shift edges.
  - CPHA=1: every bit changes on the shift (leading) edge. The first leading edge of a word must not update miso again after LOAD.
- Sample edges: shift the mosi sync value into the RX shift register and increment the bit counter, which wraps at WIDTH.
- Word completion, on the completing sample edge in cycle N:
  - Cycle N+1: rx_data = assembled word, with rx_wr_en=1 if !rx_full.
  - If rx_full, rx_wr_en stays 0 and rx_overrun=1 instead.
  - rx_data holds its value until the next completion.
- The block never asserts rx_wr_en when rx_full, and never asserts tx_rd_en when tx_empty.
- cs_n rising mid-word (bit counter != 0):
  - Partial RX word discarded, no write.
  - frame_error pulses once.
  - Counter cleared, return to IDLE, miso_oe drops.
  - A word already fetched from the TX FIFO is lost; there is no push-back.
- cs_n rising at a word boundary: no frame_error, and no extra tx_rd_en is issued.
- Reset asserted mid-transfer: reset values take effect next cycle. No strobes are issued during reset.

Test Plan:
- Mode 0, TX FIFO preloaded 0xA5; master sends 0x3C with sclk = clk/10 -> exactly one rx_wr_en with rx_data=0x3C; miso bits 1,0,1,0,0,1,0,1; exactly one tx_rd_en.
- Mode 3 (CPOL=1, CPHA=1), 3-word burst 0x01,0x80,0xFF with TX words 0x11,0x22,0x33 -> RX receives 0x01,0x80,0xFF in order; MISO carries 0x11,0x22,0x33 with no gap bits; 3 tx_rd_en.
- TX FIFO empty at CS assert, FILL_WORD=0x00 -> tx_underrun pulses once; MISO all 0; tx_rd_en never asserted.
- rx_full held high while master sends 0x55 -> rx_wr_en never asserted; rx_overrun pulses once, one cycle after the 8th sample edge.
- cs_n deasserted after 5 sclk cycles -> no rx_wr_en; frame_error pulses once; next full 0x9A frame received correctly.
- rst asserted after 3 bits of a frame -> all outputs reach their reset values next cycle; after release and a new CS assert, the transfer of 0x42 completes correctly.
